// File: rtl/gnw_save_uploader_pkg.sv
// Shared definitions for the save-RAM uploader: FSM state encoding,
// timeout read sentinel and counter sizing helper.
package gnw_save_uploader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;

    // Counter width able to hold n without wrapping.
    function automatic int unsigned cnt_width(input int unsigned n);
        return int'($clog2(n)) + 1;
    endfunction

endpackage

// File: rtl/gnw_save_uploader.sv
// Serves HPS upload reads of save RAM from a variable-latency memory and
// requests a save upload when the OSD closes with unsaved writes pending.
module gnw_save_uploader
    import gnw_save_uploader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 13,
    parameter int unsigned SAVE_WORDS  = 4096,
    parameter logic [7:0]  SAVE_INDEX  = 8'd1,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned REQ_HOLDOFF = 131072
) (
    input  logic                  clk_sys_131_072,
    input  logic                  reset,
    input  logic                  ioctl_upload,
    input  logic                  ioctl_rd,
    input  logic [24:0]           ioctl_addr,
    input  logic [7:0]            ioctl_index,
    output logic [15:0]           ioctl_din,
    output logic                  ioctl_wait,
    output logic                  ioctl_upload_req,
    input  logic                  save_wr,
    input  logic                  osd_status,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [15:0]           mem_data,
    input  logic                  mem_ack
);

    localparam int unsigned TO_W   = cnt_width(ACK_TIMEOUT);
    localparam int unsigned HOLD_W = cnt_width(REQ_HOLDOFF);
    localparam logic [TO_W-1:0]     TO_LAST   = (ACK_TIMEOUT > 0) ? TO_W'(ACK_TIMEOUT - 1) : '0;
    localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(REQ_HOLDOFF);
    localparam logic [ADDR_WIDTH:0] WORDS_LIM = (ADDR_WIDTH + 1)'(SAVE_WORDS);

    state_t                r_state;
    logic [15:0]           r_din;
    logic                  r_mem_rd;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_upload_req;
    logic                  r_dirty;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [TO_W-1:0]       r_to_cnt;
    logic                  r_prev_osd;
    logic                  r_prev_upload;

    logic [ADDR_WIDTH-1:0] w_word;
    logic                  w_hit;
    logic                  w_in_range;
    logic                  w_dirty_clr;
    logic                  w_req;
    logic                  w_unused;

    assign w_word      = ioctl_addr[ADDR_WIDTH:1];
    assign w_hit       = ioctl_rd & ioctl_upload & (ioctl_index == SAVE_INDEX);
    assign w_in_range  = {1'b0, w_word} < WORDS_LIM;
    assign w_dirty_clr = r_prev_upload & ~ioctl_upload & (ioctl_index == SAVE_INDEX);
    assign w_req       = r_prev_osd & ~osd_status & r_dirty & ~ioctl_upload & (r_hold_cnt == '0);
    assign w_unused    = ^{ioctl_addr[24:ADDR_WIDTH+1], ioctl_addr[0]};

    // Stall starts in the hit cycle itself so the HPS never samples stale data.
    assign ioctl_wait       = ~reset & ((r_state != ST_IDLE) | (w_hit & w_in_range));
    assign ioctl_din        = r_din;
    assign ioctl_upload_req = r_upload_req;
    assign mem_rd           = r_mem_rd;
    assign mem_addr         = r_mem_addr;

    // Read fetch FSM.
    always_ff @(posedge clk_sys_131_072 or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_din      <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_mem_rd <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        if (w_in_range) begin
                            r_mem_addr <= w_word;
                            r_mem_rd   <= 1'b1;
                            r_state    <= ST_FETCH;
                        end else begin
                            r_din <= '0;
                        end
                    end
                end
                ST_FETCH: begin
                    r_to_cnt <= '0;
                    r_state  <= ioctl_upload ? ST_WAIT_ACK : ST_IDLE;
                end
                ST_WAIT_ACK: begin
                    // An abandoned upload wins over a coincident ack.
                    if (!ioctl_upload) begin
                        r_state <= ST_IDLE;
                    end else if (mem_ack) begin
                        r_din   <= mem_data;
                        r_state <= ST_IDLE;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_din   <= TIMEOUT_DATA;
                        r_state <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Dirty tracking and rate-limited save request.
    always_ff @(posedge clk_sys_131_072 or posedge reset) begin
        if (reset) begin
            r_dirty       <= 1'b0;
            r_upload_req  <= 1'b0;
            r_hold_cnt    <= '0;
            r_prev_osd    <= 1'b0;
            r_prev_upload <= 1'b0;
        end else begin
            r_prev_osd    <= osd_status;
            r_prev_upload <= ioctl_upload;
            r_upload_req  <= w_req;
            if (save_wr) begin
                r_dirty <= 1'b1;
            end else if (w_dirty_clr) begin
                r_dirty <= 1'b0;
            end
            if (w_req) begin
                r_hold_cnt <= HOLD_LOAD;
            end else if (r_hold_cnt != '0) begin
                r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
            end
        end
    end

endmodule
